// File: rtl/spmv_row_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spmv_row_acc_ctrl
// Brief    : Sequences FP16 row accumulation through a fixed-latency adder and
//            emits one row sum per row. Optional macro SPMV_NNZ_COUNT_EN adds
//            a per-row non-zero product count on out_nnz.
// Revision : 1.0 - initial release
// ============================================================================
module spmv_row_acc_ctrl #(
    parameter int ADD_LAT = 1,
    parameter int ROW_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    input  logic             in_empty,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    output logic             add_en,
    input  logic [15:0]      add_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [ROW_W-1:0] out_row,
    output logic             busy
`ifdef SPMV_NNZ_COUNT_EN
    ,
    output logic [ROW_W-1:0] out_nnz
`endif
);

    localparam logic [2:0] c_LAT = 3'(ADD_LAT);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_WAIT   = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_acc;
    logic [2:0]  r_cnt;
    logic        r_last;
    logic        w_in_hs;
    logic        w_out_hs;
    logic        w_cnt_done;

    assign w_in_hs    = in_valid & in_ready;
    assign w_out_hs   = out_valid & out_ready;
    assign w_cnt_done = (r_state == ST_WAIT) && (r_cnt == 3'd0);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= ST_ACCEPT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_ACCEPT: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_in_hs) begin
                    w_state_nxt = in_empty ? ST_OUT : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = r_last ? ST_OUT : ST_ACCEPT;
                end
            end
            ST_OUT: begin
                if (w_out_hs) begin
                    w_state_nxt = ST_ACCEPT;
                end
            end
            default: w_state_nxt = ST_ACCEPT;
        endcase
    end

    // The counter is loaded with ADD_LAT so that it reads zero exactly in the
    // cycle where the adder presents the sum for the issued operands.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_acc     <= 16'h0000;
            r_cnt     <= 3'd0;
            r_last    <= 1'b0;
            add_a     <= 16'h0000;
            add_b     <= 16'h0000;
            add_en    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            out_row   <= '0;
        end else begin
            add_en <= 1'b0;
            case (r_state)
                ST_ACCEPT: begin
                    if (w_in_hs) begin
                        if (in_empty) begin
                            out_data  <= 16'h0000;
                            out_valid <= 1'b1;
                        end else begin
                            add_a  <= in_data;
                            add_b  <= r_acc;
                            add_en <= 1'b1;
                            r_last <= in_last;
                            r_cnt  <= c_LAT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        if (r_last) begin
                            out_data  <= add_result;
                            out_valid <= 1'b1;
                            r_acc     <= 16'h0000;
                        end else begin
                            r_acc <= add_result;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_OUT: begin
                    if (w_out_hs) begin
                        out_valid <= 1'b0;
                        out_row   <= out_row + ROW_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPMV_NNZ_COUNT_EN
    logic [ROW_W-1:0] r_nnz;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_nnz   <= '0;
            out_nnz <= '0;
        end else begin
            if ((r_state == ST_OUT) && w_out_hs) begin
                r_nnz <= '0;
            end else if ((r_state == ST_ACCEPT) && w_in_hs && !in_empty && (r_nnz != '1)) begin
                r_nnz <= r_nnz + ROW_W'(1);
            end
            if ((r_state == ST_ACCEPT) && w_in_hs && in_empty) begin
                out_nnz <= '0;
            end else if (w_cnt_done && r_last) begin
                out_nnz <= r_nnz;
            end
        end
    end
`endif

endmodule
`default_nettype wire
